// File: rtl/id_ex_if.sv
// Decode/execute-side bundle of the ID/EX pipeline register.
// The stage uses the slave view; the decode/write-back/execute environment uses master.
interface id_ex_if #(
  parameter int CTRL_W = 8
);
  // decode side
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic [63:0]       rd1;
  logic [63:0]       rd2;
  logic [63:0]       imm;
  logic [4:0]        wa;
  logic              mem_read;
  logic              reg_write;
  logic [CTRL_W-1:0] ctrl;
  // write-back snoop (same signals as regfile port 3)
  logic              wb_we;
  logic [4:0]        wb_wa;
  logic [63:0]       wb_wd;
  // execute side
  logic              ex_valid;
  logic              ex_ready;
  logic [63:0]       ex_rd1;
  logic [63:0]       ex_rd2;
  logic [63:0]       ex_imm;
  logic [4:0]        ex_wa;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [CTRL_W-1:0] ex_ctrl;

  modport slave (
    input  flush, in_valid, ra1, ra2, rd1, rd2, imm, wa, mem_read, reg_write, ctrl,
    input  wb_we, wb_wa, wb_wd, ex_ready,
    output in_ready, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_wa, ex_mem_read, ex_reg_write, ex_ctrl
  );

  modport master (
    output flush, in_valid, ra1, ra2, rd1, rd2, imm, wa, mem_read, reg_write, ctrl,
    output wb_we, wb_wa, wb_wd, ex_ready,
    input  in_ready, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_wa, ex_mem_read, ex_reg_write, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion
// (STALL_CYCLES bubbles per hazard), valid/ready handshake and branch flush.
// Optional macro ID_EX_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module id_ex_stage #(
  parameter int STALL_CYCLES = 1,
  parameter int CTRL_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  id_ex_if.slave      bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic { RUN, STALL } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              ex_valid_q;
  logic [63:0]       ex_rd1_q, ex_rd2_q, ex_imm_q;
  logic [4:0]        ex_wa_q;
  logic              ex_mem_read_q, ex_reg_write_q;
  logic [CTRL_W-1:0] ex_ctrl_q;

  logic advance, hazard, hit1, hit2, in_ready, xfer, byp1, byp2;

  // handshake, hazard and bypass selection
  always_comb begin
    advance  = !ex_valid_q || bus.ex_ready;
    hit1     = (ex_wa_q == bus.ra1) && (bus.ra1 != XZR);
    hit2     = (ex_wa_q == bus.ra2) && (bus.ra2 != XZR);
    hazard   = ex_valid_q && ex_mem_read_q && ex_reg_write_q && (ex_wa_q != XZR) && (hit1 || hit2);
    in_ready = (state == RUN) && advance && !hazard && !bus.flush;
    xfer     = bus.in_valid && in_ready;
    // XZR reads are hardwired zero in the regfile, so never forward into them
    byp1     = bus.wb_we && (bus.wb_wa != XZR) && (bus.wb_wa == bus.ra1);
    byp2     = bus.wb_we && (bus.wb_wa != XZR) && (bus.wb_wa == bus.ra2);
  end

  // stall FSM next state; flush overrides any pending bubbles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          // the hazard cycle itself already yields the first bubble
          if (hazard && advance && (STALL_CYCLES > 1)) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_W'(STALL_CYCLES - 1);
          end
        end
        STALL: begin
          if (advance) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // stall FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // pipeline register; data regs simply hold on bubbles and flushes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q     <= 1'b0;
      ex_rd1_q       <= '0;
      ex_rd2_q       <= '0;
      ex_imm_q       <= '0;
      ex_wa_q        <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_ctrl_q      <= '0;
    end else if (bus.flush) begin
      ex_valid_q     <= 1'b0;
    end else if (advance) begin
      ex_valid_q <= xfer;
      if (xfer) begin
        ex_rd1_q       <= byp1 ? bus.wb_wd : bus.rd1;
        ex_rd2_q       <= byp2 ? bus.wb_wd : bus.rd2;
        ex_imm_q       <= bus.imm;
        ex_wa_q        <= bus.wa;
        ex_mem_read_q  <= bus.mem_read;
        ex_reg_write_q <= bus.reg_write;
        ex_ctrl_q      <= bus.ctrl;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // perf counters: decode blocked cycles and flushes that killed a live instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.in_valid && !in_ready && !bus.flush) stall_cnt <= stall_cnt + 32'd1;
      if (bus.flush && ex_valid_q)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

  assign bus.in_ready     = in_ready;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_rd1       = ex_rd1_q;
  assign bus.ex_rd2       = ex_rd2_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_wa        = ex_wa_q;
  assign bus.ex_mem_read  = ex_mem_read_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_ctrl      = ex_ctrl_q;

endmodule
